// File: rtl/mult_div_unit.sv
//==============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit. A start accepted while
//               idle computes the full 64-bit result at once into a pending
//               register, then a down-counter models the architectural latency
//               (5 cycles multiply, 10 cycles divide) before HI/LO update.
//               Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    localparam logic [3:0] c_OP_MULT  = 4'd0;
    localparam logic [3:0] c_OP_MULTU = 4'd1;
    localparam logic [3:0] c_OP_DIV   = 4'd2;
    localparam logic [3:0] c_OP_DIVU  = 4'd3;
    localparam logic [3:0] c_OP_MTHI  = 4'd4;
    localparam logic [3:0] c_OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd6;
    localparam logic [3:0] c_OP_MADDU = 4'd7;
    localparam logic [3:0] c_OP_MSUB  = 4'd8;
    localparam logic [3:0] c_OP_MSUBU = 4'd9;
`endif

    localparam logic [3:0] c_LAT_MUL  = 4'd5;
    localparam logic [3:0] c_LAT_DIV  = 4'd10;

    logic [3:0]  r_count;
    logic [63:0] r_pending;
    logic        r_wr;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic [63:0] w_a_sext;
    logic [63:0] w_b_sext;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_div;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [3:0]  w_load_cnt;
    logic [63:0] w_result;
    logic        w_wr;
    logic        w_mthi;
    logic        w_mtlo;

    assign busy     = (r_count != 4'd0);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign done     = r_done;
    assign w_accept = start & ~busy;

    // Products: a 64x64 multiply of the extended operands keeps the low 64
    // bits exact for both two's-complement and unsigned interpretations.
    assign w_a_sext = {{32{src_a[31]}}, src_a};
    assign w_b_sext = {{32{src_b[31]}}, src_b};
    assign w_prod_s = w_a_sext * w_b_sext;
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Division on magnitudes, signs reapplied afterwards. This makes
    // 0x80000000 / -1 fall out naturally as quotient 0x80000000, remainder 0.
    // A zero divisor is replaced by 1 only to keep the divider defined; the
    // result is never written in that case.
    assign w_div_signed = (op == c_OP_DIV);
    assign w_a_neg      = w_div_signed & src_a[31];
    assign w_b_neg      = w_div_signed & src_b[31];
    assign w_a_mag      = w_a_neg ? (~src_a + 32'd1) : src_a;
    assign w_b_mag      = w_b_neg ? (~src_b + 32'd1) : src_b;
    assign w_b_div      = (src_b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_div;
    assign w_r_mag      = w_a_mag % w_b_div;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // Operation decode: latency to load, result to park, and whether it writes.
    always_comb begin
        w_load_cnt = 4'd0;
        w_result   = 64'd0;
        w_wr       = 1'b0;
        w_mthi     = 1'b0;
        w_mtlo     = 1'b0;
        case (op)
            c_OP_MULT: begin
                w_load_cnt = c_LAT_MUL;
                w_result   = w_prod_s;
                w_wr       = 1'b1;
            end
            c_OP_MULTU: begin
                w_load_cnt = c_LAT_MUL;
                w_result   = w_prod_u;
                w_wr       = 1'b1;
            end
            c_OP_DIV, c_OP_DIVU: begin
                w_load_cnt = c_LAT_DIV;
                w_result   = {w_rem, w_quot};
                w_wr       = (src_b != 32'd0);
            end
            c_OP_MTHI: w_mthi = 1'b1;
            c_OP_MTLO: w_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            c_OP_MADD: begin
                w_load_cnt = c_LAT_MUL;
                w_result   = {r_hi, r_lo} + w_prod_s;
                w_wr       = 1'b1;
            end
            c_OP_MADDU: begin
                w_load_cnt = c_LAT_MUL;
                w_result   = {r_hi, r_lo} + w_prod_u;
                w_wr       = 1'b1;
            end
            c_OP_MSUB: begin
                w_load_cnt = c_LAT_MUL;
                w_result   = {r_hi, r_lo} - w_prod_s;
                w_wr       = 1'b1;
            end
            c_OP_MSUBU: begin
                w_load_cnt = c_LAT_MUL;
                w_result   = {r_hi, r_lo} - w_prod_u;
                w_wr       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Latency counter and pending result, loaded only when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= 4'd0;
            r_pending <= 64'd0;
            r_wr      <= 1'b0;
        end else if (busy) begin
            r_count <= r_count - 4'd1;
        end else if (w_accept && (w_load_cnt != 4'd0)) begin
            r_count   <= w_load_cnt;
            r_pending <= w_result;
            r_wr      <= w_wr;
        end
    end

    // HI/LO: retire the pending result on the final count, or direct moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_count == 4'd1) begin
            if (r_wr) begin
                r_hi <= r_pending[63:32];
                r_lo <= r_pending[31:0];
            end
        end else if (w_accept) begin
            if (w_mthi) begin
                r_hi <= src_a;
            end
            if (w_mtlo) begin
                r_lo <= src_a;
            end
        end
    end

    // Done pulses in the cycle right after the retiring edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_count == 4'd1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
//==============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit with a behavioural
//               arithmetic model of HI/LO and operation latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural model: new HI/LO and latency for one accepted operation.
    function automatic void model(input logic [3:0] mop, input logic [31:0] a,
                                  input logic [31:0] b, inout logic [31:0] h,
                                  inout logic [31:0] l, output int lat);
        int          sa;
        int          sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = a;
        sb  = b;
        lat = 0;
        case (mop)
            4'd0: begin p = longint'(sa) * longint'(sb); {h, l} = p; lat = 5; end
            4'd1: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; lat = 5; end
            4'd2: begin
                lat = 10;
                if (b != 0) begin
                    q = longint'(sa) / longint'(sb);
                    r = longint'(sa) % longint'(sb);
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            4'd3: begin
                lat = 10;
                if (b != 0) begin
                    l = a / b;
                    h = a % b;
                end
            end
            4'd4: h = a;
            4'd5: l = a;
`ifdef MDU_MADD_EN
            4'd6: begin p = longint'(sa) * longint'(sb); {h, l} = {h, l} + p; lat = 5; end
            4'd7: begin p = {32'd0, a} * {32'd0, b};     {h, l} = {h, l} + p; lat = 5; end
            4'd8: begin p = longint'(sa) * longint'(sb); {h, l} = {h, l} - p; lat = 5; end
            4'd9: begin p = {32'd0, a} * {32'd0, b};     {h, l} = {h, l} - p; lat = 5; end
`endif
            default: ;
        endcase
    endfunction

    // Issue one op in the current cycle, then follow it to completion.
    // Returns in the first busy=0 cycle so the next call issues back-to-back.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit inj);
        logic [31:0] oh;
        logic [31:0] ol;
        int          lat;
        int          n;
        oh = m_hi;
        ol = m_lo;
        model(o, a, b, m_hi, m_lo, lat);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 4'($urandom_range(0, 15));
        src_a = $urandom;
        src_b = $urandom;
        check("done_low_after_accept", {63'd0, done}, 64'd0);
        if (lat == 0) begin
            check("busy_noop", {63'd0, busy}, 64'd0);
            check("hilo_immediate", {hi, lo}, {m_hi, m_lo});
            return;
        end
        check("hilo_held_while_busy", {hi, lo}, {oh, ol});
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            if (inj && n == 1) begin
                start = 1'b1;
                op    = 4'd3;
                src_a = $urandom;
                src_b = $urandom_range(1, 9);
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("busy_cycles", 64'(n), 64'(lat));
        check("done_pulse", {63'd0, done}, 64'd1);
        check("hilo_result", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        bit          saw;
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Signed multiply of -2 by 3.
        do_op(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // Unsigned and signed division.
        do_op(4'd3, 32'd100, 32'd7, 1'b0);
        check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        do_op(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});

        // Divide by zero leaves HI/LO intact.
        do_op(4'd4, 32'h11, 32'd0, 1'b0);
        do_op(4'd5, 32'h22, 32'd0, 1'b0);
        do_op(4'd2, 32'h1234_5678, 32'd0, 1'b0);
        check("div_by_zero", {hi, lo}, {32'h11, 32'h22});

        // Start during busy is ignored; next op issued in the first idle cycle.
        do_op(4'd1, 32'h0001_0000, 32'h0001_0000, 1'b1);
        check("multu_ignore_second", {hi, lo}, {32'd1, 32'd0});
        do_op(4'd0, 32'd3, 32'd4, 1'b0);
        check("back_to_back", {hi, lo}, {32'd0, 32'd12});

        // Accumulate op: result depends on the build.
        do_op(4'd4, 32'd0, 32'd0, 1'b0);
        do_op(4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op(4'd7, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        check("maddu_carry", {hi, lo}, {32'd1, 32'd0});
`else
        check("maddu_noop", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

        // Reserved code.
        do_op(4'd12, 32'hDEAD_BEEF, 32'd5, 1'b0);

        // Random operations, including reserved codes and zero divisors.
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 1) rb = 32'($urandom_range(1, 300));
            do_op(ro, ra, rb, ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a divide discards it.
        start = 1'b1;
        op    = 4'd2;
        src_a = 32'd1000;
        src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("busy_before_reset", {63'd0, busy}, 64'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        saw = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) saw = 1'b1;
        end
        check("no_late_activity", {63'd0, saw}, 64'd0);
        check("no_late_update", {hi, lo}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
